multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle instruction sequencer for the core datapath. It steps each instruction through fetch, decode, execute, memory and writeback, handshaking with instruction/data memory. It drives the immediate extender's `imm_src` select and the datapath enables: PC, instruction register, register file, memory and result muxes. It also counts retired instructions.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: level enable. The sequencer leaves IDLE only while this is high.
- `instr` in 32: instruction register contents. Sampled in DECODE.
- `zero` in 1: ALU zero flag. Sampled in BRANCH.
- `mem_ready` in 1: memory access complete. Observed only in FETCH and MEM_ACC.
- `imm_src` out 2: extender select. 0 = 10-bit DP immediate, 1 = 12-bit MEM offset, 2 = 20-bit BR offset, 3 = illegal (extender yields 0).
- `ir_write`, `pc_write`, `pc_src` out 1 each: `pc_src` selects 0 = PC+4, 1 = PC+extended immediate.
- `addr_src` out 1: 0 = PC, 1 = address register.
- `addr_write` out 1: load the address register.
- `mem_read`, `mem_write` out 1 each.
- `alu_src_b` out 1: 0 = register, 1 = extended immediate.
- `reg_write` out 1.
- `result_src` out 1: 0 = ALU, 1 = memory data.
- `fault` out 1: sticky illegal-opcode flag.
- `state` out 4: current state encoding.
- `retired` out CNT_W: count of retired instructions.

## Operation
- Decode fields in `instr`:
  - `op` = `[27:26]`: 00 DP, 01 MEM, 10 BR, 11 illegal.
  - `[25]` = DP immediate flag.
  - `[20]` = MEM load (1) / store (0).
  - `[24]` = BR conditional.
- DECODE latches `op`, I, L and C into internal registers. `imm_src` is a register loaded in DECODE from `op` (00→0, 01→1, 10→2, 11→3). It holds that value until the next DECODE.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM_ADDR=4, MEM_ACC=5, WB=6, BRANCH=7, FAULT=8.
- IDLE: all strobes 0. Go to FETCH when `run`=1.
- FETCH: `mem_read`=1, `addr_src`=0.
  - `mem_ready`=0: stay.
  - `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0 in the same cycle, then go to DECODE.
- DECODE: no strobes. Next state by `op`: DP→EXEC, MEM→MEM_ADDR, BR→BRANCH, illegal→FAULT.
- EXEC: `alu_src_b` = latched I. Go to WB.
- MEM_ADDR: `alu_src_b`=1, `addr_write`=1. Go to MEM_ACC.
- MEM_ACC: `addr_src`=1, `mem_read`=L, `mem_write`=!L. Hold until `mem_ready`=1.
  - Load: go to WB with `result_src`=1.
  - Store: retire.
- WB: `reg_write`=1. `result_src` = 1 for a load, 0 for DP. Retire.
- BRANCH: taken = !C or `zero`.
  - Taken: `pc_write`=1, `pc_src`=1.
  - Either way: retire.
- Retire: `retired` increments by 1, wrapping from 2^CNT_W−1 to 0. Next state is FETCH if `run`=1, else IDLE.
- FAULT: `fault`=1, all other strobes 0. Absorbing; only `rst` exits. `run` is ignored.
- Deasserting `run` mid-instruction does not abort. The instruction completes and retires, then the sequencer enters IDLE.
- `mem_ready` outside FETCH and MEM_ACC is ignored.
- Outputs are a combinational decode of `state`, the latched fields, `zero` and `mem_ready`. `imm_src`, `retired`, `fault` and `state` are registers.

## Timing
- Reset (async, immediate): `state`=IDLE, `imm_src`=0, `retired`=0, `fault`=0. All strobes 0.
- Minimum cycles with `mem_ready` tied high:
  - DP: 4 (FETCH, DECODE, EXEC, WB).
  - Load: 5.
  - Store: 4.
  - Branch: 3.
- Each wait cycle with `mem_ready`=0 in FETCH or MEM_ACC adds one cycle. All strobes hold steady during the wait.
- `imm_src` is valid from the cycle after DECODE through the end of the instruction. It is stable during EXEC, MEM_ADDR and BRANCH.
- `retired` updates on the clock edge that leaves the retiring state.
- `run` is sampled in IDLE and on the retire edge only.
- Reset asserted mid-access drops `mem_read`/`mem_write` immediately. No partial retire is counted.

## Test plan
- DP immediate: `instr[27:26]`=00, `[25]`=1, `mem_ready`=1 → `imm_src`=0. States 1,2,3,6; `alu_src_b`=1 in EXEC; `reg_write` one cycle; `retired` 0→1.
- Load with 3-cycle memory stall in MEM_ACC: op=01, L=1 → `imm_src`=1. `mem_read` and `addr_src`=1 held 3 cycles; WB with `result_src`=1; 8 cycles total.
- Branch, conditional with `zero`=0, then `zero`=1: op=10, C=1 → `imm_src`=2. First: no `pc_write` in BRANCH. Second: `pc_write`=1, `pc_src`=1. `retired` +2.
- Illegal op=11 → `imm_src`=3, `state`=8, `fault`=1. Toggling `run` has no effect. Asserting `rst` mid-cycle clears all outputs asynchronously.
- `run` dropped during MEM_ACC of a store → store completes (`mem_write` until `mem_ready`), `retired` increments, then `state`=IDLE with all strobes 0.
- Counter wrap with CNT_W=4: 16 DP instructions → `retired` returns to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle sequencer: FETCH/DECODE/EXEC/MEM_ADDR/MEM_ACC/WB/BRANCH, 3-5 cycles per instruction.
// Latency grows by one cycle per mem_ready=0 cycle in FETCH or MEM_ACC; strobes hold while stalled.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       imm_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             addr_src,
  output logic             addr_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src_b,
  output logic             reg_write,
  output logic             result_src,
  output logic             fault,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_ACC  = 4'd5,
    S_WB       = 4'd6,
    S_BRANCH   = 4'd7,
    S_FAULT    = 4'd8
  } state_t;

  state_t     cur_state;
  state_t     nxt_state;
  logic       imm_q;
  logic       load_q;
  logic       cond_q;
  logic       retire;
  logic [1:0] op;

  assign op    = instr[27:26];
  assign state = cur_state;

  logic unused_instr;
  assign unused_instr = ^{instr[31:28], instr[23:21], instr[19:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= S_IDLE;
      imm_q     <= 1'b0;
      load_q    <= 1'b0;
      cond_q    <= 1'b0;
      imm_src   <= 2'd0;
      retired   <= '0;
      fault     <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_DECODE) begin
        imm_q   <= instr[25];
        // Only a MEM op may steer the result mux to memory data in WB.
        load_q  <= (op == 2'b01) && instr[20];
        cond_q  <= instr[24];
        imm_src <= op;
      end
      if (retire) begin
        retired <= retired + CNT_W'(1);
      end
      if (nxt_state == S_FAULT) begin
        fault <= 1'b1;
      end
    end
  end

  always_comb begin
    nxt_state  = cur_state;
    retire     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    addr_src   = 1'b0;
    addr_write = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_b  = 1'b0;
    reg_write  = 1'b0;
    result_src = 1'b0;

    case (cur_state)
      S_IDLE: begin
        if (run) begin
          nxt_state = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          nxt_state = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op)
          2'b00:   nxt_state = S_EXEC;
          2'b01:   nxt_state = S_MEM_ADDR;
          2'b10:   nxt_state = S_BRANCH;
          default: nxt_state = S_FAULT;
        endcase
      end
      S_EXEC: begin
        alu_src_b = imm_q;
        nxt_state = S_WB;
      end
      S_MEM_ADDR: begin
        alu_src_b  = 1'b1;
        addr_write = 1'b1;
        nxt_state  = S_MEM_ACC;
      end
      S_MEM_ACC: begin
        addr_src  = 1'b1;
        mem_read  = load_q;
        mem_write = !load_q;
        if (mem_ready) begin
          if (load_q) begin
            nxt_state = S_WB;
          end else begin
            retire = 1'b1;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        result_src = load_q;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        if (!cond_q || zero) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end
        retire = 1'b1;
      end
      S_FAULT: begin
        nxt_state = S_FAULT;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase

    // run is only consulted at the retire edge, so a drop never aborts.
    if (retire) begin
      nxt_state = run ? S_FETCH : S_IDLE;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (CNT_W=4): inputs change on negedge, outputs checked 1ns later.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_EXEC = 4'd3,
                         ST_MADDR = 4'd4, ST_MACC = 4'd5, ST_WB = 4'd6, ST_BRANCH = 4'd7,
                         ST_FAULT = 4'd8;

  // {ir_write,pc_write,pc_src,addr_src,addr_write,mem_read,mem_write,alu_src_b,reg_write,result_src}
  localparam logic [9:0] SB_NONE      = 10'b0000000000;
  localparam logic [9:0] SB_FETCH_RDY = 10'b1100010000;
  localparam logic [9:0] SB_FETCH_WT  = 10'b0000010000;
  localparam logic [9:0] SB_EXEC_IMM  = 10'b0000000100;
  localparam logic [9:0] SB_MADDR     = 10'b0000100100;
  localparam logic [9:0] SB_MACC_LD   = 10'b0001010000;
  localparam logic [9:0] SB_MACC_ST   = 10'b0001001000;
  localparam logic [9:0] SB_WB_DP     = 10'b0000000010;
  localparam logic [9:0] SB_WB_LD     = 10'b0000000011;
  localparam logic [9:0] SB_BR_TAKEN  = 10'b0110000000;

  localparam logic [31:0] I_DP_IMM = 32'h0200_0000;
  localparam logic [31:0] I_DP_REG = 32'h0000_0000;
  localparam logic [31:0] I_LOAD   = 32'h0410_0000;
  localparam logic [31:0] I_STORE  = 32'h0400_0000;
  localparam logic [31:0] I_BR_CND = 32'h0900_0000;
  localparam logic [31:0] I_ILL    = 32'h0C00_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic [31:0]      instr;
  logic             zero;
  logic             mem_ready;
  logic [1:0]       imm_src;
  logic             ir_write, pc_write, pc_src, addr_src, addr_write;
  logic             mem_read, mem_write, alu_src_b, reg_write, result_src;
  logic             fault;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;
  logic [9:0]       strobes;

  int errors = 0;
  int checks = 0;

  assign strobes = {ir_write, pc_write, pc_src, addr_src, addr_write,
                    mem_read, mem_write, alu_src_b, reg_write, result_src};

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .imm_src(imm_src), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .addr_src(addr_src), .addr_write(addr_write), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src_b(alu_src_b), .reg_write(reg_write), .result_src(result_src), .fault(fault),
    .state(state), .retired(retired)
  );

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({state, imm_src, fault, retired, strobes} !== {ST_IDLE, 2'd0, 1'b0, 4'd0, SB_NONE}) begin
      errors++;
      $display("FAIL reset: state=%0d imm_src=%0d fault=%b retired=%0d strobes=%b, want 0/0/0/0/%b",
               state, imm_src, fault, retired, strobes, SB_NONE);
    end
    @(negedge clk); rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({state, strobes} !== {ST_IDLE, SB_NONE}) begin
      errors++;
      $display("FAIL idle_no_run: state=%0d strobes=%b, want %0d %b", state, strobes, ST_IDLE, SB_NONE);
    end
  endtask

  task automatic test_dp_imm();
    logic [3:0] exp_st [4] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_WB};
    logic [9:0] exp_sb [4] = '{SB_FETCH_RDY, SB_NONE, SB_EXEC_IMM, SB_WB_DP};
    instr = I_DP_IMM; run = 1'b1; mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 3) run = 1'b0;
      #1;
      checks++;
      if ({state, strobes, retired} !== {exp_st[c], exp_sb[c], 4'd0}) begin
        errors++;
        $display("FAIL dp_imm[%0d]: state=%0d strobes=%b retired=%0d, want %0d %b 0",
                 c, state, strobes, retired, exp_st[c], exp_sb[c]);
      end
      if (c == 2) begin
        checks++;
        if (imm_src !== 2'd0) begin
          errors++;
          $display("FAIL dp_imm_src: imm_src=%0d, want 0", imm_src);
        end
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({state, strobes, retired} !== {ST_IDLE, SB_NONE, 4'd1}) begin
      errors++;
      $display("FAIL dp_retire: state=%0d strobes=%b retired=%0d, want 0 %b 1", state, strobes, retired, SB_NONE);
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [3:0] exp_st [4] = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_WB};
    logic [9:0] exp_sb [4] = '{SB_FETCH_RDY, SB_NONE, SB_NONE, SB_WB_DP};
    instr = I_DP_REG; run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (i == 14 && c == 3) run = 1'b0;
        #1;
        checks++;
        if ({state, strobes} !== {exp_st[c], exp_sb[c]}) begin
          errors++;
          $display("FAIL b2b[%0d][%0d]: state=%0d strobes=%b, want %0d %b",
                   i, c, state, strobes, exp_st[c], exp_sb[c]);
        end
      end
      checks++;
      if (retired !== 4'(i + 1)) begin
        errors++;
        $display("FAIL b2b_count[%0d]: retired=%0d, want %0d", i, retired, i + 1);
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({state, retired} !== {ST_IDLE, 4'd0}) begin
      errors++;
      $display("FAIL wrap: state=%0d retired=%0d, want 0 0", state, retired);
    end
  endtask

  task automatic test_load_stall();
    logic [3:0] exp_st [8] = '{ST_FETCH, ST_DECODE, ST_MADDR, ST_MACC, ST_MACC, ST_MACC, ST_MACC, ST_WB};
    logic [9:0] exp_sb [8] = '{SB_FETCH_RDY, SB_NONE, SB_MADDR, SB_MACC_LD, SB_MACC_LD,
                               SB_MACC_LD, SB_MACC_LD, SB_WB_LD};
    instr = I_LOAD; run = 1'b1; mem_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      mem_ready = !(c >= 3 && c <= 5);
      if (c == 7) run = 1'b0;
      #1;
      checks++;
      if ({state, strobes} !== {exp_st[c], exp_sb[c]}) begin
        errors++;
        $display("FAIL load[%0d]: state=%0d strobes=%b, want %0d %b", c, state, strobes, exp_st[c], exp_sb[c]);
      end
    end
    checks++;
    if (imm_src !== 2'd1) begin
      errors++;
      $display("FAIL load_imm_src: imm_src=%0d, want 1", imm_src);
    end
    @(negedge clk); #1;
    checks++;
    if ({state, retired} !== {ST_IDLE, 4'd1}) begin
      errors++;
      $display("FAIL load_retire: state=%0d retired=%0d, want 0 1", state, retired);
    end
  endtask

  task automatic test_branch();
    logic [3:0] exp_st [3] = '{ST_FETCH, ST_DECODE, ST_BRANCH};
    instr = I_BR_CND; run = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (c == 0) zero = (b == 1);
        if (b == 1 && c == 2) run = 1'b0;
        #1;
        checks++;
        if (state !== exp_st[c]) begin
          errors++;
          $display("FAIL br[%0d] state[%0d]: state=%0d, want %0d", b, c, state, exp_st[c]);
        end
      end
      checks++;
      if ({imm_src, strobes, retired} !== {2'd2, (b == 1) ? SB_BR_TAKEN : SB_NONE, 4'(1 + b)}) begin
        errors++;
        $display("FAIL br[%0d] in BRANCH: imm_src=%0d strobes=%b retired=%0d", b, imm_src, strobes, retired);
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({state, retired} !== {ST_IDLE, 4'd3}) begin
      errors++;
      $display("FAIL br_retire: state=%0d retired=%0d, want 0 3", state, retired);
    end
  endtask

  task automatic test_store_run_drop();
    logic [3:0] exp_st [6] = '{ST_FETCH, ST_DECODE, ST_MADDR, ST_MACC, ST_MACC, ST_MACC};
    logic [9:0] exp_sb [6] = '{SB_FETCH_RDY, SB_NONE, SB_MADDR, SB_MACC_ST, SB_MACC_ST, SB_MACC_ST};
    instr = I_STORE; run = 1'b1; mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 3) run = 1'b0;
      mem_ready = !(c == 3 || c == 4);
      #1;
      checks++;
      if ({state, strobes, retired} !== {exp_st[c], exp_sb[c], 4'd3}) begin
        errors++;
        $display("FAIL store[%0d]: state=%0d strobes=%b retired=%0d, want %0d %b 3",
                 c, state, strobes, retired, exp_st[c], exp_sb[c]);
      end
    end
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if ({state, strobes, retired} !== {ST_IDLE, SB_NONE, 4'd4}) begin
        errors++;
        $display("FAIL store_idle: state=%0d strobes=%b retired=%0d, want 0 %b 4", state, strobes, retired, SB_NONE);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    instr = I_LOAD; run = 1'b1; mem_ready = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({state, strobes} !== {ST_FETCH, SB_FETCH_WT}) begin
      errors++;
      $display("FAIL fetch_wait: state=%0d strobes=%b, want 1 %b", state, strobes, SB_FETCH_WT);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({state, strobes, retired} !== {ST_IDLE, SB_NONE, 4'd0}) begin
      errors++;
      $display("FAIL async_rst_access: state=%0d strobes=%b retired=%0d, want 0 %b 0", state, strobes, retired, SB_NONE);
    end
    @(negedge clk); rst = 1'b0; run = 1'b0;
  endtask

  task automatic test_fault();
    instr = I_ILL; run = 1'b1; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({state, fault, imm_src, strobes} !== {ST_FAULT, 1'b1, 2'd3, SB_NONE}) begin
      errors++;
      $display("FAIL fault_enter: state=%0d fault=%b imm_src=%0d strobes=%b, want 8 1 3 %b",
               state, fault, imm_src, strobes, SB_NONE);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      run = c[0];
      #1;
      checks++;
      if ({state, fault, strobes, retired} !== {ST_FAULT, 1'b1, SB_NONE, 4'd0}) begin
        errors++;
        $display("FAIL fault_hold[%0d]: state=%0d fault=%b strobes=%b retired=%0d", c, state, fault, strobes, retired);
      end
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({state, fault, imm_src, strobes, retired} !== {ST_IDLE, 1'b0, 2'd0, SB_NONE, 4'd0}) begin
      errors++;
      $display("FAIL fault_rst: state=%0d fault=%b imm_src=%0d strobes=%b retired=%0d",
               state, fault, imm_src, strobes, retired);
    end
    @(negedge clk); rst = 1'b0; run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dp_imm();
    test_back_to_back_wrap();
    test_load_stall();
    test_branch();
    test_store_run_drop();
    test_reset_mid_access();
    test_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
